// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top : single-cycle MIPS-like datapath (fetch, decode, ALU, data RAM, RF)
// One instruction completes per clock. The instruction ROM is loaded from the
// ROM_IMAGE parameter at elaboration (word i at bits [32*i +: 32]).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module top #(
  parameter logic [64*32-1:0] ROM_IMAGE = '0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] inst,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] PC,
  output logic [31:0] PC_new,
  output logic [2:0]  ALU_OP,
  output logic [31:0] ALU_B,
  output logic [31:0] ALU_Data,
  output logic [31:0] ZF,
  output logic [31:0] OF,
  output logic        Write_Reg,
  output logic        Mem_Write,
  output logic        rd_rt_s,
  output logic        imm_s,
  output logic        rt_imm_s,
  output logic        alu_mem_s,
  output logic [4:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic [31:0] imm_data,
  output logic [31:0] M_R_Data
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] regs_q [32];
  logic [31:0] dmem_q [64];
  logic        zf_w;
  logic        of_w;
  logic [5:0]  opcode_w;
  logic [5:0]  funct_w;

  // Fetch and field extraction
  assign pc_d     = pc_q + 32'd4;
  assign PC       = pc_q;
  assign PC_new   = pc_d;
  assign inst     = ROM_IMAGE[32*pc_q[7:2] +: 32];
  assign opcode_w = inst[31:26];
  assign funct_w  = inst[5:0];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign imm      = inst[15:0];

  // Register-file reads; r0 is hard-wired to zero
  assign rs_data = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rt_data = (rt == 5'd0) ? 32'd0 : regs_q[rt];

  // Instruction decode; anything unrecognised degenerates to a no-op
  always_comb begin
    ALU_OP    = OP_ADD;
    Write_Reg = 1'b0;
    Mem_Write = 1'b0;
    rd_rt_s   = 1'b0;
    imm_s     = 1'b0;
    rt_imm_s  = 1'b0;
    alu_mem_s = 1'b0;
    case (opcode_w)
      6'h00: begin
        Write_Reg = 1'b1;
        rd_rt_s   = 1'b1;
        case (funct_w)
          6'h20:   ALU_OP = OP_ADD;
          6'h22:   ALU_OP = OP_SUB;
          6'h24:   ALU_OP = OP_AND;
          6'h25:   ALU_OP = OP_OR;
          6'h26:   ALU_OP = OP_XOR;
          6'h27:   ALU_OP = OP_NOR;
          6'h2A:   ALU_OP = OP_SLT;
          6'h04:   ALU_OP = OP_SLL;
          default: begin
            Write_Reg = 1'b0;
            rd_rt_s   = 1'b0;
          end
        endcase
      end
      6'h08: begin ALU_OP = OP_ADD; imm_s = 1'b1; rt_imm_s = 1'b1; Write_Reg = 1'b1; end
      6'h0A: begin ALU_OP = OP_SLT; imm_s = 1'b1; rt_imm_s = 1'b1; Write_Reg = 1'b1; end
      6'h0C: begin ALU_OP = OP_AND; rt_imm_s = 1'b1; Write_Reg = 1'b1; end
      6'h0D: begin ALU_OP = OP_OR;  rt_imm_s = 1'b1; Write_Reg = 1'b1; end
      6'h0E: begin ALU_OP = OP_XOR; rt_imm_s = 1'b1; Write_Reg = 1'b1; end
      6'h23: begin
        ALU_OP    = OP_ADD;
        imm_s     = 1'b1;
        rt_imm_s  = 1'b1;
        alu_mem_s = 1'b1;
        Write_Reg = 1'b1;
      end
      6'h2B: begin
        ALU_OP    = OP_ADD;
        imm_s     = 1'b1;
        rt_imm_s  = 1'b1;
        Mem_Write = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand selection
  assign imm_data = imm_s ? {{16{imm[15]}}, imm} : {16'd0, imm};
  assign ALU_B    = rt_imm_s ? imm_data : rt_data;

  // ALU with signed-overflow detection restricted to ADD/SUB
  always_comb begin
    ALU_Data = 32'd0;
    of_w     = 1'b0;
    case (ALU_OP)
      OP_AND: ALU_Data = rs_data & ALU_B;
      OP_OR:  ALU_Data = rs_data | ALU_B;
      OP_XOR: ALU_Data = rs_data ^ ALU_B;
      OP_NOR: ALU_Data = ~(rs_data | ALU_B);
      OP_ADD: begin
        ALU_Data = rs_data + ALU_B;
        of_w     = (rs_data[31] == ALU_B[31]) && (ALU_Data[31] != rs_data[31]);
      end
      OP_SUB: begin
        ALU_Data = rs_data - ALU_B;
        of_w     = (rs_data[31] != ALU_B[31]) && (ALU_Data[31] != rs_data[31]);
      end
      OP_SLT: ALU_Data = ($signed(rs_data) < $signed(ALU_B)) ? 32'd1 : 32'd0;
      OP_SLL: ALU_Data = ALU_B << rs_data[4:0];
      default: ALU_Data = 32'd0;
    endcase
  end

  assign zf_w = (ALU_Data == 32'd0);
  assign ZF   = {31'd0, zf_w};
  assign OF   = {31'd0, of_w};

  // Data memory read and writeback selection
  assign M_R_Data = dmem_q[ALU_Data[7:2]];
  assign W_Addr   = rd_rt_s ? rd : rt;
  assign W_Data   = alu_mem_s ? M_R_Data : ALU_Data;

  // PC register: restart at 0 on reset, otherwise advance one word
  always_ff @(posedge clk) begin
    if (reset) pc_q <= 32'd0;
    else       pc_q <= pc_d;
  end

  // Register file: cleared by reset, writes to r0 discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (Write_Reg && (W_Addr != 5'd0)) begin
      regs_q[W_Addr] <= W_Data;
    end
  end

  // Data RAM: contents survive reset, store blocked while reset is high
  always_ff @(posedge clk) begin
    if (!reset && Mem_Write) dmem_q[ALU_Data[7:2]] <= rt_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// tb_top : scoreboard bench for the single-cycle datapath in top
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_top;

  // Program, word 0 at the least significant end
  localparam logic [64*32-1:0] PROG = {1408'h0,
    32'h00000000, 32'h38CF00FF, 32'h284E0000, 32'h00086820, 32'h20000009,
    32'h8C080008, 32'hAC010008, 32'h00212820, 32'h8C010000, 32'hAC0C0000,
    32'h01606027, 32'h01495804, 32'h200A001F, 32'h20090001, 32'h2007FFFF,
    32'h3406FFFF, 32'h00212022, 32'h00221820, 32'h2002FFFD, 32'h20010005};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst, rs_data, rt_data, PC, PC_new, ALU_B, ALU_Data, ZF, OF;
  logic [31:0] W_Data, imm_data, M_R_Data;
  logic [4:0]  rs, rt, rd, W_Addr;
  logic [15:0] imm;
  logic [2:0]  ALU_OP;
  logic        Write_Reg, Mem_Write, rd_rt_s, imm_s, rt_imm_s, alu_mem_s;

  top #(.ROM_IMAGE(PROG)) dut (
    .clk(clk), .reset(reset), .inst(inst), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .rs_data(rs_data), .rt_data(rt_data), .PC(PC),
    .PC_new(PC_new), .ALU_OP(ALU_OP), .ALU_B(ALU_B), .ALU_Data(ALU_Data),
    .ZF(ZF), .OF(OF), .Write_Reg(Write_Reg), .Mem_Write(Mem_Write),
    .rd_rt_s(rd_rt_s), .imm_s(imm_s), .rt_imm_s(rt_imm_s),
    .alu_mem_s(alu_mem_s), .W_Addr(W_Addr), .W_Data(W_Data),
    .imm_data(imm_data), .M_R_Data(M_R_Data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [2:0]  op;
    logic [31:0] alu;
    logic        zf, of, wr, mw;
    logic [4:0]  wa;
    logic [31:0] wd, rsd, rtd;
    logic [3:0]  sel;   // {rd_rt_s, imm_s, rt_imm_s, alu_mem_s}
  } exp_t;

  exp_t        tbl [20];
  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [64*32-1:0] img;

  function automatic exp_t mk(int i, logic [2:0] op, logic [31:0] alu,
                              logic zf, logic of, logic wr, logic mw,
                              logic [4:0] wa, logic [31:0] wd,
                              logic [31:0] rsd, logic [31:0] rtd, logic [3:0] sel);
    exp_t e;
    e.idx = i; e.pc = 32'(i * 4); e.op = op; e.alu = alu; e.zf = zf; e.of = of;
    e.wr = wr; e.mw = mw; e.wa = wa; e.wd = wd; e.rsd = rsd; e.rtd = rtd; e.sel = sel;
    return e;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @step%0d: got %h expected %h", name, idx, act, exp);
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc",       e.idx, PC, e.pc);
        chk("pc_new",   e.idx, PC_new, e.pc + 32'd4);
        chk("inst",     e.idx, inst, img[32*e.idx +: 32]);
        chk("alu_op",   e.idx, {29'd0, ALU_OP}, {29'd0, e.op});
        chk("alu_data", e.idx, ALU_Data, e.alu);
        chk("zf",       e.idx, ZF, {31'd0, e.zf});
        chk("of",       e.idx, OF, {31'd0, e.of});
        chk("wr_mw",    e.idx, {30'd0, Write_Reg, Mem_Write}, {30'd0, e.wr, e.mw});
        chk("w_addr",   e.idx, {27'd0, W_Addr}, {27'd0, e.wa});
        chk("w_data",   e.idx, W_Data, e.wd);
        chk("rs_data",  e.idx, rs_data, e.rsd);
        chk("rt_data",  e.idx, rt_data, e.rtd);
        chk("selects",  e.idx, {28'd0, rd_rt_s, imm_s, rt_imm_s, alu_mem_s},
                               {28'd0, e.sel});
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Stimulus: one expectation per executed instruction
  initial begin
    img = PROG;
    tbl[0]  = mk(0,  3'd4, 32'h00000005, 0,0,1,0, 5'd1,  32'h00000005, 32'h0,        32'h0,        4'b0110);
    tbl[1]  = mk(1,  3'd4, 32'hFFFFFFFD, 0,0,1,0, 5'd2,  32'hFFFFFFFD, 32'h0,        32'h0,        4'b0110);
    tbl[2]  = mk(2,  3'd4, 32'h00000002, 0,0,1,0, 5'd3,  32'h00000002, 32'h5,        32'hFFFFFFFD, 4'b1000);
    tbl[3]  = mk(3,  3'd5, 32'h00000000, 1,0,1,0, 5'd4,  32'h00000000, 32'h5,        32'h5,        4'b1000);
    tbl[4]  = mk(4,  3'd1, 32'h0000FFFF, 0,0,1,0, 5'd6,  32'h0000FFFF, 32'h0,        32'h0,        4'b0010);
    tbl[5]  = mk(5,  3'd4, 32'hFFFFFFFF, 0,0,1,0, 5'd7,  32'hFFFFFFFF, 32'h0,        32'h0,        4'b0110);
    tbl[6]  = mk(6,  3'd4, 32'h00000001, 0,0,1,0, 5'd9,  32'h00000001, 32'h0,        32'h0,        4'b0110);
    tbl[7]  = mk(7,  3'd4, 32'h0000001F, 0,0,1,0, 5'd10, 32'h0000001F, 32'h0,        32'h0,        4'b0110);
    tbl[8]  = mk(8,  3'd7, 32'h80000000, 0,0,1,0, 5'd11, 32'h80000000, 32'h1F,       32'h1,        4'b1000);
    tbl[9]  = mk(9,  3'd3, 32'h7FFFFFFF, 0,0,1,0, 5'd12, 32'h7FFFFFFF, 32'h80000000, 32'h0,        4'b1000);
    tbl[10] = mk(10, 3'd4, 32'h00000000, 1,0,0,1, 5'd12, 32'h00000000, 32'h0,        32'h7FFFFFFF, 4'b0110);
    tbl[11] = mk(11, 3'd4, 32'h00000000, 1,0,1,0, 5'd1,  32'h7FFFFFFF, 32'h0,        32'h5,        4'b0111);
    tbl[12] = mk(12, 3'd4, 32'hFFFFFFFE, 0,1,1,0, 5'd5,  32'hFFFFFFFE, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b1000);
    tbl[13] = mk(13, 3'd4, 32'h00000008, 0,0,0,1, 5'd1,  32'h00000008, 32'h0,        32'h7FFFFFFF, 4'b0110);
    tbl[14] = mk(14, 3'd4, 32'h00000008, 0,0,1,0, 5'd8,  32'h7FFFFFFF, 32'h0,        32'h0,        4'b0111);
    tbl[15] = mk(15, 3'd4, 32'h00000009, 0,0,1,0, 5'd0,  32'h00000009, 32'h0,        32'h0,        4'b0110);
    tbl[16] = mk(16, 3'd4, 32'h7FFFFFFF, 0,0,1,0, 5'd13, 32'h7FFFFFFF, 32'h0,        32'h7FFFFFFF, 4'b1000);
    tbl[17] = mk(17, 3'd6, 32'h00000001, 0,0,1,0, 5'd14, 32'h00000001, 32'hFFFFFFFD, 32'h0,        4'b0110);
    tbl[18] = mk(18, 3'd2, 32'h0000FF00, 0,0,1,0, 5'd15, 32'h0000FF00, 32'h0000FFFF, 32'h0,        4'b0010);
    tbl[19] = mk(19, 3'd4, 32'h00000000, 1,0,0,0, 5'd0,  32'h00000000, 32'h0,        32'h0,        4'b0000);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(tbl[0]);       // decode of ROM[0] while reset is held
    reset = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
      sb_q.push_back(tbl[i]);
    end
    reset = 1'b1;                 // mid-run reset: fetch restarts at 0, RF cleared
    @(posedge clk); #1;
    sb_q.push_back(tbl[0]);
    reset = 1'b0;
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      sb_q.push_back(tbl[i]);
    end
    @(negedge clk); #1;
    chk("queue_drain", 0, 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
